cp0_tlb_ctrl: RTL and testbench

- CP0-side initiator for the 8-entry TLB used by the MMU map top.
- Holds the Index, Random, Wired, EntryHi, EntryLo0 and EntryLo1 architectural registers.
- Sequences TLBP, TLBR, TLBWI and TLBWR requests from the execute stage into single-cycle strobes on the TLB, then captures the probe and read results back into the registers.
- Also supplies curr_ASID, cp0_index and cp0_random to the MMU.

---
 rtl/cp0_tlb_ctrl.sv | 168 ++++++++++++++++
 tb/tb_cp0_tlb_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_tlb_ctrl.sv
// rtl/cp0_tlb_ctrl.sv - CP0 TLB register file and TLBP/TLBR/TLBWI/TLBWR sequencer
module cp0_tlb_ctrl #(
   parameter int TLB_ENTRIES  = 8,
   parameter int RANDOM_RESET = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        op_valid,
   input  logic [1:0]  op_code,
   output logic        op_ready,
   output logic        op_done,
   input  logic        cp0_we,
   input  logic [4:0]  cp0_waddr,
   input  logic [31:0] cp0_wdata,
   input  logic [4:0]  cp0_raddr,
   output logic [31:0] cp0_rdata,
   output logic        tlbwi,
   output logic        tlbwr,
   output logic        tlbp,
   output logic [2:0]  cp0_index,
   output logic [2:0]  cp0_random,
   output logic [85:0] tlb_conf_wdata,
   input  logic [85:0] tlb_conf_rdata,
   input  logic        miss_probe,
   input  logic [3:0]  matched_index_probe,
   output logic [7:0]  curr_ASID
);

   localparam int IW = $clog2(TLB_ENTRIES);
   localparam logic [IW-1:0] RAND_RST = IW'(RANDOM_RESET);

   localparam logic [1:0] OP_TLBP  = 2'b00;
   localparam logic [1:0] OP_TLBR  = 2'b01;
   localparam logic [1:0] OP_TLBWI = 2'b10;
   localparam logic [1:0] OP_TLBWR = 2'b11;

   localparam logic [4:0] R_INDEX   = 5'd0;
   localparam logic [4:0] R_RANDOM  = 5'd1;
   localparam logic [4:0] R_LO0     = 5'd2;
   localparam logic [4:0] R_LO1     = 5'd3;
   localparam logic [4:0] R_WIRED   = 5'd6;
   localparam logic [4:0] R_ENTRYHI = 5'd10;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [1:0]    op_q;

   logic          p_q;
   logic [IW-1:0] idx_q;
   logic [IW-1:0] random_q;
   logic [IW-1:0] wired_q;
   logic [18:0]   vpn2_q;
   logic [7:0]    asid_q;
   // EntryLo held as {PFN, C, D, V, G}
   logic [25:0]   lo0_q;
   logic [25:0]   lo1_q;

   logic          wired_write;
   logic          unused_bits;

   assign unused_bits = ^{matched_index_probe[3], tlb_conf_rdata[7:0]};
   assign wired_write = cp0_we && (cp0_waddr == R_WIRED);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         op_q    <= OP_TLBP;
      end else begin
         state_q <= state_d;
         if (op_valid && op_ready)
            op_q <= op_code;
      end
   end

   always_comb begin
      state_d  = state_q;
      op_ready = 1'b0;
      op_done  = 1'b0;
      tlbp     = 1'b0;
      tlbwi    = 1'b0;
      tlbwr    = 1'b0;
      case (state_q)
         S_IDLE: begin
            op_ready = 1'b1;
            if (op_valid)
               state_d = S_ISSUE;
         end
         S_ISSUE: begin
            tlbp    = (op_q == OP_TLBP);
            tlbwi   = (op_q == OP_TLBWI);
            tlbwr   = (op_q == OP_TLBWR);
            state_d = S_DONE;
         end
         S_DONE: begin
            op_done = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Captures are written after MTC0 so a same-cycle capture wins.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         p_q      <= 1'b0;
         idx_q    <= '0;
         random_q <= RAND_RST;
         wired_q  <= '0;
         vpn2_q   <= '0;
         asid_q   <= '0;
         lo0_q    <= '0;
         lo1_q    <= '0;
      end else begin
         if (cp0_we) begin
            case (cp0_waddr)
               R_INDEX:   idx_q   <= cp0_wdata[IW-1:0];
               R_LO0:     lo0_q   <= cp0_wdata[25:0];
               R_LO1:     lo1_q   <= cp0_wdata[25:0];
               R_WIRED:   wired_q <= cp0_wdata[IW-1:0];
               R_ENTRYHI: begin
                  vpn2_q <= cp0_wdata[31:13];
                  asid_q <= cp0_wdata[7:0];
               end
               default: ;
            endcase
         end

         if (wired_write)
            random_q <= RAND_RST;
         else if (state_q == S_IDLE)
            random_q <= (random_q == wired_q) ? RAND_RST : random_q - IW'(1);

         if (state_q == S_DONE) begin
            if (op_q == OP_TLBP) begin
               p_q <= miss_probe;
               if (!miss_probe)
                  idx_q <= matched_index_probe[IW-1:0];
            end else if (op_q == OP_TLBR) begin
               vpn2_q <= tlb_conf_rdata[85:67];
               asid_q <= tlb_conf_rdata[66:59];
               lo0_q  <= {tlb_conf_rdata[58:34], tlb_conf_rdata[8]};
               lo1_q  <= {tlb_conf_rdata[33:9],  tlb_conf_rdata[8]};
            end
         end
      end
   end

   assign cp0_index      = idx_q;
   assign cp0_random     = random_q;
   assign curr_ASID      = asid_q;
   assign tlb_conf_wdata = {vpn2_q, asid_q, lo0_q[25:1], lo1_q[25:1],
                            lo0_q[0] & lo1_q[0], 8'h00};

   always_comb begin
      cp0_rdata = 32'h0;
      case (cp0_raddr)
         R_INDEX:   cp0_rdata = {p_q, 28'b0, idx_q};
         R_RANDOM:  cp0_rdata = {29'b0, random_q};
         R_LO0:     cp0_rdata = {6'b0, lo0_q};
         R_LO1:     cp0_rdata = {6'b0, lo1_q};
         R_WIRED:   cp0_rdata = {29'b0, wired_q};
         R_ENTRYHI: cp0_rdata = {vpn2_q, 5'b0, asid_q};
         default:   cp0_rdata = 32'h0;
      endcase
   end

endmodule

// File: tb/tb_cp0_tlb_ctrl.sv
// tb/tb_cp0_tlb_ctrl.sv - directed bench for cp0_tlb_ctrl
module tb_cp0_tlb_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        op_valid;
   logic [1:0]  op_code;
   logic        op_ready;
   logic        op_done;
   logic        cp0_we;
   logic [4:0]  cp0_waddr;
   logic [31:0] cp0_wdata;
   logic [4:0]  cp0_raddr;
   logic [31:0] cp0_rdata;
   logic        tlbwi, tlbwr, tlbp;
   logic [2:0]  cp0_index;
   logic [2:0]  cp0_random;
   logic [85:0] tlb_conf_wdata;
   logic [85:0] tlb_conf_rdata;
   logic        miss_probe;
   logic [3:0]  matched_index_probe;
   logic [7:0]  curr_ASID;

   int n_cmp = 0;
   int n_err = 0;

   cp0_tlb_ctrl #(.TLB_ENTRIES(8), .RANDOM_RESET(7)) dut (
      .clk(clk), .rst(rst),
      .op_valid(op_valid), .op_code(op_code), .op_ready(op_ready), .op_done(op_done),
      .cp0_we(cp0_we), .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata),
      .cp0_raddr(cp0_raddr), .cp0_rdata(cp0_rdata),
      .tlbwi(tlbwi), .tlbwr(tlbwr), .tlbp(tlbp),
      .cp0_index(cp0_index), .cp0_random(cp0_random),
      .tlb_conf_wdata(tlb_conf_wdata), .tlb_conf_rdata(tlb_conf_rdata),
      .miss_probe(miss_probe), .matched_index_probe(matched_index_probe),
      .curr_ASID(curr_ASID)
   );

   always #5 clk = ~clk;

   task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
      cp0_we    = 1'b1;
      cp0_waddr = addr;
      cp0_wdata = data;
      @(negedge clk);
      cp0_we    = 1'b0;
   endtask

   task automatic read_reg(input logic [4:0] addr, output logic [31:0] data);
      cp0_raddr = addr;
      #1;
      data = cp0_rdata;
   endtask

   task automatic test_reset;
      logic [31:0] r;
      rst = 1'b0;
      op_valid = 1'b0; op_code = 2'b00;
      cp0_we = 1'b0; cp0_waddr = '0; cp0_wdata = '0; cp0_raddr = '0;
      tlb_conf_rdata = '0; miss_probe = 1'b0; matched_index_probe = '0;
      @(negedge clk);
      @(negedge clk);
      n_cmp++;
      if ({op_ready, op_done, tlbp, tlbwi, tlbwr} !== 5'b10000) begin
         n_err++;
         $display("FAIL reset_ctrl: got %b want 10000", {op_ready, op_done, tlbp, tlbwi, tlbwr});
      end
      n_cmp++;
      if (cp0_random !== 3'd7) begin
         n_err++;
         $display("FAIL reset_random: got %0d want 7", cp0_random);
      end
      read_reg(5'd10, r);
      n_cmp++;
      if (r !== 32'h0 || cp0_index !== 3'd0 || tlb_conf_wdata !== 86'h0) begin
         n_err++;
         $display("FAIL reset_regs: entryhi %h idx %0d wdata %h want zeros", r, cp0_index, tlb_conf_wdata);
      end
      rst = 1'b1;
   endtask

   task automatic test_random_idle;
      logic [2:0] exp_seq [10] = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7, 3'd6};
      for (int i = 0; i < 10; i++) begin
         n_cmp++;
         if (cp0_random !== exp_seq[i] || op_ready !== 1'b1 || {tlbp, tlbwi, tlbwr} !== 3'b000) begin
            n_err++;
            $display("FAIL random_idle[%0d]: random %0d ready %b strobes %b want %0d 1 000",
                     i, cp0_random, op_ready, {tlbp, tlbwi, tlbwr}, exp_seq[i]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_wired;
      logic [2:0]  exp_seq [6] = '{3'd7, 3'd6, 3'd5, 3'd7, 3'd6, 3'd5};
      logic [31:0] r;
      int          k;
      k = 0;
      while (cp0_random !== 3'd2 && k < 20) begin
         @(negedge clk);
         k++;
      end
      n_cmp++;
      if (cp0_random !== 3'd2) begin
         n_err++;
         $display("FAIL wired_wait: random %0d never reached 2", cp0_random);
      end
      mtc0(5'd6, 32'h0000_0005);
      read_reg(5'd6, r);
      n_cmp++;
      if (r !== 32'h5) begin
         n_err++;
         $display("FAIL wired_read: got %h want 00000005", r);
      end
      for (int i = 0; i < 6; i++) begin
         n_cmp++;
         if (cp0_random !== exp_seq[i]) begin
            n_err++;
            $display("FAIL wired_seq[%0d]: got %0d want %0d", i, cp0_random, exp_seq[i]);
         end
         @(negedge clk);
      end
      mtc0(5'd6, 32'h0000_0007);
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (cp0_random !== 3'd7) begin
            n_err++;
            $display("FAIL wired7_hold[%0d]: got %0d want 7", i, cp0_random);
         end
         @(negedge clk);
      end
      mtc0(5'd6, 32'h0000_0000);
   endtask

   task automatic test_tlbwi;
      logic [31:0] r;
      mtc0(5'd10, 32'h0040_2005);
      mtc0(5'd2, 32'h0000_0041);
      mtc0(5'd3, 32'h0000_0043);
      mtc0(5'd0, 32'h0000_0003);
      read_reg(5'd10, r);
      n_cmp++;
      if (r !== 32'h0040_2005) begin
         n_err++;
         $display("FAIL entryhi_read: got %h want 00402005", r);
      end
      op_valid = 1'b1; op_code = 2'b10;
      n_cmp++;
      if (op_ready !== 1'b1) begin
         n_err++;
         $display("FAIL tlbwi_ready: got %b want 1", op_ready);
      end
      @(negedge clk);
      op_valid = 1'b0;
      n_cmp++;
      if ({tlbp, tlbwi, tlbwr, op_done, op_ready} !== 5'b01000 || cp0_index !== 3'd3) begin
         n_err++;
         $display("FAIL tlbwi_issue: strobes/done/ready %b idx %0d want 01000 3",
                  {tlbp, tlbwi, tlbwr, op_done, op_ready}, cp0_index);
      end
      n_cmp++;
      if (tlb_conf_wdata[85:67] !== 19'h201 || tlb_conf_wdata[66:59] !== 8'h05 ||
          tlb_conf_wdata[58:34] !== 25'h20 || tlb_conf_wdata[33:9] !== 25'h21 ||
          tlb_conf_wdata[8] !== 1'b1 || tlb_conf_wdata[7:0] !== 8'h00) begin
         n_err++;
         $display("FAIL tlbwi_image: got %h want vpn2 201 asid 05 lo0 20 lo1 21 g 1", tlb_conf_wdata);
      end
      @(negedge clk);
      n_cmp++;
      if ({tlbwi, op_done, op_ready} !== 3'b010) begin
         n_err++;
         $display("FAIL tlbwi_done: tlbwi/done/ready %b want 010", {tlbwi, op_done, op_ready});
      end
      @(negedge clk);
      n_cmp++;
      if ({op_done, op_ready} !== 2'b01) begin
         n_err++;
         $display("FAIL tlbwi_idle: done/ready %b want 01", {op_done, op_ready});
      end
   endtask

   task automatic run_tlbp(input logic miss, input logic [3:0] match, input logic [31:0] exp_index);
      logic [31:0] r;
      miss_probe = miss; matched_index_probe = match;
      op_valid = 1'b1; op_code = 2'b00;
      @(negedge clk);
      op_valid = 1'b0;
      n_cmp++;
      if ({tlbp, tlbwi, tlbwr} !== 3'b100) begin
         n_err++;
         $display("FAIL tlbp_issue: strobes %b want 100", {tlbp, tlbwi, tlbwr});
      end
      @(negedge clk);
      n_cmp++;
      if ({tlbp, op_done} !== 2'b01) begin
         n_err++;
         $display("FAIL tlbp_done: tlbp/done %b want 01", {tlbp, op_done});
      end
      @(negedge clk);
      read_reg(5'd0, r);
      n_cmp++;
      if (r !== exp_index) begin
         n_err++;
         $display("FAIL tlbp_index(miss=%b): got %h want %h", miss, r, exp_index);
      end
   endtask

   task automatic test_tlbp;
      run_tlbp(1'b0, 4'h6, 32'h0000_0006);
      run_tlbp(1'b1, 4'h2, 32'h8000_0006);
   endtask

   task automatic test_tlbr;
      logic [31:0] r;
      tlb_conf_rdata = {19'h1ABCD, 8'h3C,
                        20'h12345, 3'd3, 1'b1, 1'b1,
                        20'hABCDE, 3'd2, 1'b0, 1'b1,
                        1'b0, 8'h00};
      op_valid = 1'b1; op_code = 2'b01;
      @(negedge clk);
      op_valid = 1'b0;
      n_cmp++;
      if ({tlbp, tlbwi, tlbwr} !== 3'b000) begin
         n_err++;
         $display("FAIL tlbr_issue: strobes %b want 000", {tlbp, tlbwi, tlbwr});
      end
      @(negedge clk);
      cp0_we = 1'b1; cp0_waddr = 5'd10; cp0_wdata = 32'hFFFF_FFFF;
      n_cmp++;
      if (op_done !== 1'b1) begin
         n_err++;
         $display("FAIL tlbr_done: got %b want 1", op_done);
      end
      @(negedge clk);
      cp0_we = 1'b0;
      n_cmp++;
      if (curr_ASID !== 8'h3C) begin
         n_err++;
         $display("FAIL tlbr_asid: got %h want 3c", curr_ASID);
      end
      read_reg(5'd10, r);
      n_cmp++;
      if (r !== 32'h3579_A03C) begin
         n_err++;
         $display("FAIL tlbr_entryhi: got %h want 3579a03c", r);
      end
      read_reg(5'd2, r);
      n_cmp++;
      if (r !== 32'h0048_D15E) begin
         n_err++;
         $display("FAIL tlbr_lo0: got %h want 0048d15e", r);
      end
      read_reg(5'd3, r);
      n_cmp++;
      if (r !== 32'h02AF_3792) begin
         n_err++;
         $display("FAIL tlbr_lo1: got %h want 02af3792", r);
      end
   endtask

   task automatic test_tlbwr_and_abort;
      logic [31:0] r;
      int          k;
      k = 0;
      while (cp0_random !== 3'd5 && k < 20) begin
         @(negedge clk);
         k++;
      end
      n_cmp++;
      if (cp0_random !== 3'd5) begin
         n_err++;
         $display("FAIL tlbwr_wait: random %0d never reached 5", cp0_random);
      end
      op_valid = 1'b1; op_code = 2'b11;
      @(negedge clk);
      op_valid = 1'b0;
      n_cmp++;
      if ({tlbp, tlbwi, tlbwr} !== 3'b001 || cp0_random !== 3'd4) begin
         n_err++;
         $display("FAIL tlbwr_issue: strobes %b random %0d want 001 4", {tlbp, tlbwi, tlbwr}, cp0_random);
      end
      @(negedge clk);
      n_cmp++;
      if ({tlbwr, op_done} !== 2'b01 || cp0_random !== 3'd4) begin
         n_err++;
         $display("FAIL tlbwr_done: tlbwr/done %b random %0d want 01 4", {tlbwr, op_done}, cp0_random);
      end
      @(negedge clk);
      n_cmp++;
      if (cp0_random !== 3'd4) begin
         n_err++;
         $display("FAIL tlbwr_frozen: got %0d want 4", cp0_random);
      end
      op_valid = 1'b1; op_code = 2'b10;
      @(negedge clk);
      op_valid = 1'b0;
      n_cmp++;
      if (tlbwi !== 1'b1) begin
         n_err++;
         $display("FAIL abort_issue: tlbwi %b want 1", tlbwi);
      end
      rst = 1'b0;
      read_reg(5'd0, r);
      n_cmp++;
      if ({tlbwi, op_done, op_ready} !== 3'b001 || cp0_random !== 3'd7 || r !== 32'h0 || curr_ASID !== 8'h00) begin
         n_err++;
         $display("FAIL abort_reset: tlbwi/done/ready %b random %0d index %h asid %h want 001 7 0 0",
                  {tlbwi, op_done, op_ready}, cp0_random, r, curr_ASID);
      end
      @(negedge clk);
      n_cmp++;
      if ({tlbwi, op_done} !== 2'b00) begin
         n_err++;
         $display("FAIL abort_hold: tlbwi/done %b want 00", {tlbwi, op_done});
      end
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (op_done !== 1'b0 || op_ready !== 1'b1 || cp0_random !== 3'd6) begin
         n_err++;
         $display("FAIL abort_after: done %b ready %b random %0d want 0 1 6", op_done, op_ready, cp0_random);
      end
   endtask

   initial begin
      test_reset();
      test_random_idle();
      test_wired();
      test_tlbwi();
      test_tlbp();
      test_tlbr();
      test_tlbwr_and_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
